counter_down_reload: RTL and testbench

Parametrised loadable down counter with reload register, enable, periodic/one-shot modes and registered terminal-count and half-count pulses. It is the general-purpose timebase for the peripheral controllers. In RS232 RX it divides CLK to the bit period, and HALF marks mid-bit sampling. It supersedes the single-mode down counter with zero flag: Z is kept, and reload and pulse generation are now internal.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_down_reload.sv | 76 +++++++
 tb/tb_counter_down_reload.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the reloadable down-counter timebase.
package counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_down_reload.sv
// Loadable down counter with reload register, periodic/one-shot modes and
// registered terminal-count (TC) and half-period (HALF) pulses.
module counter_down_reload
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] COUNTER,
    output logic             Z,
    output logic             TC,
    output logic             HALF,
    output logic             BUSY
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] kreg, kreg_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic             tc_nxt, half_nxt;
    logic [WIDTH-1:0] half_point;

    assign half_point = kreg >> 1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            kreg  <= '0;
            count <= '0;
            TC    <= 1'b0;
            HALF  <= 1'b0;
        end else begin
            state <= state_nxt;
            kreg  <= kreg_nxt;
            count <= count_nxt;
            TC    <= tc_nxt;
            HALF  <= half_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kreg_nxt  = kreg;
        count_nxt = count;
        tc_nxt    = 1'b0;
        half_nxt  = 1'b0;
        if (LOAD) begin
            kreg_nxt  = K;
            count_nxt = K;
            state_nxt = ST_RUN;
        end else if (state == ST_RUN && EN) begin
            if (count == '0) begin
                tc_nxt = 1'b1;
                if (MODE == MODE_PERIODIC) begin
                    count_nxt = kreg;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end else begin
                count_nxt = count - WIDTH'(1);
                // HALF rises together with the count reaching KREG>>1, so it
                // leads the following TC by (KREG>>1)+1 cycles.
                half_nxt  = (half_point != '0) && (count_nxt == half_point);
            end
        end
    end

    assign COUNTER = count;
    assign Z       = (count == '0);
    assign BUSY    = (state == ST_RUN);

endmodule : counter_down_reload

// File: tb/tb_counter_down_reload.sv
// Directed bench for counter_down_reload at WIDTH=4 with immediate assertions.
module tb_counter_down_reload;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             LOAD;
    logic             EN;
    logic             MODE;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] COUNTER;
    logic             Z, TC, HALF, BUSY;

    int checks = 0;
    int errors = 0;

    counter_down_reload #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD), .EN(EN), .MODE(MODE), .K(K),
        .COUNTER(COUNTER), .Z(Z), .TC(TC), .HALF(HALF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit tc, input bit half, input bit busy);
        chk({tag, "_cnt"}, 32'(COUNTER), 32'(cnt));
        chk({tag, "_z"}, 32'(Z), 32'(cnt == 0));
        chk({tag, "_tc"}, 32'(TC), 32'(tc));
        chk({tag, "_half"}, 32'(HALF), 32'(half));
        chk({tag, "_busy"}, 32'(BUSY), 32'(busy));
    endtask

    task automatic do_load(input int kval, input bit mode);
        LOAD = 1'b1; K = WIDTH'(kval); MODE = mode;
        step();
        LOAD = 1'b0;
    endtask

    initial begin
        int e;
        int exp_cnt;
        RESET_N = 1'b0; LOAD = 1'b0; EN = 1'b0; MODE = 1'b0; K = '0;
        step(); step();
        chk_all("reset", 0, 0, 0, 0);
        RESET_N = 1'b1;

        // IDLE ignores EN
        EN = 1'b1;
        step();
        chk_all("idle_en", 0, 0, 0, 0);

        // Periodic K=5: 4,3,2,1,0,5,... TC at i=6,12, HALF while COUNTER=2
        do_load(5, 1'b0);
        chk_all("per5_load", 5, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_cnt = (i % 6 == 0) ? 5 : 5 - (i % 6);
            chk_all($sformatf("per5_%0d", i), exp_cnt, (i % 6 == 0), (i % 6 == 3), 1);
        end

        // One-shot K=3: single TC 4 cycles after LOAD, BUSY drops with it
        do_load(3, 1'b1);
        chk_all("os3_load", 3, 0, 0, 1);
        step(); chk_all("os3_1", 2, 0, 0, 1);
        step(); chk_all("os3_2", 1, 0, 1, 1);
        step(); chk_all("os3_3", 0, 0, 0, 1);
        step(); chk_all("os3_4", 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all($sformatf("os3_idle%0d", i), 0, 0, 0, 0);
        end

        // EN gating K=4: TC after 5 enabled edges, count frozen while EN=0
        EN = 1'b0;
        do_load(4, 1'b0);
        chk_all("gate_load", 4, 0, 0, 1);
        e = 0;
        for (int j = 0; j < 10; j++) begin
            EN = (j % 2 == 1);
            step();
            if (EN) e++;
            exp_cnt = (e < 5) ? 4 - e : 4;
            chk_all($sformatf("gate_%0d", j), exp_cnt, (EN && e == 5), (EN && e == 2), 1);
        end

        // LOAD on the expiry cycle wins and suppresses TC
        EN = 1'b1;
        step(); step(); step(); step();
        chk_all("coll_pre", 0, 0, 0, 1);
        do_load(7, 1'b0);
        chk_all("coll_load", 7, 0, 0, 1);

        // Async reset mid-run clears at once; stays IDLE afterwards
        step();
        chk_all("rst_pre", 6, 0, 0, 1);
        RESET_N = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 0);
        RESET_N = 1'b1;
        step();
        chk_all("rst_post", 0, 0, 0, 0);

        // K=0 periodic: TC every enabled cycle, never HALF
        do_load(0, 1'b0);
        chk_all("k0_load", 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all($sformatf("k0_%0d", i), 0, 1, 0, 1);
        end

        // K=1: TC every 2 cycles, never HALF
        do_load(1, 1'b0);
        chk_all("k1_load", 1, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_all($sformatf("k1_%0d", i), (i % 2 == 0) ? 1 : 0, (i % 2 == 0), 0, 1);
        end

        // K=15: HALF while COUNTER=7, TC 16 cycles after LOAD
        do_load(15, 1'b0);
        chk_all("k15_load", 15, 0, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk_all($sformatf("k15_%0d", i), (i == 16) ? 15 : 15 - i, (i == 16), (i == 8), 1);
        end

        // MODE switched to one-shot mid-run applies at the next expiry
        do_load(2, 1'b0);
        step(); chk_all("mode_1", 1, 0, 1, 1);
        MODE = 1'b1;
        step(); chk_all("mode_2", 0, 0, 0, 1);
        step(); chk_all("mode_3", 0, 1, 0, 0);
        step(); chk_all("mode_4", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_down_reload
